div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand width in bits.
REQ-002 SHALL have parameter CNT_W, default 6, iteration counter width; it holds the value WIDTH.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 rst  input  1  reset, asynchronous, active-low: rst=0 resets immediately, with no dependence on clk.
REQ-005 signed_div  input  1  1 = two's-complement division, 0 = unsigned.
REQ-006 opdata1  input  WIDTH  dividend.
REQ-007 opdata2  input  WIDTH  divisor.
REQ-008 start  input  1  request from the EX stage; held high until the result is consumed.
REQ-009 annul  input  1  cancel the in-flight division (branch flush).
REQ-010 result  output  2*WIDTH  {remainder, quotient}; the upper half feeds hi and the lower half feeds lo.
REQ-011 ready  output  1  result valid, registered.
REQ-012 busy  output  1  division in progress; the EX stage uses it as a stall request.

Function
REQ-013 SHALL implement 4 states: FREE, BYZERO, ON, END.
REQ-014 In FREE, when start=1 and annul=0 with opdata2=0, SHALL go to BYZERO.
REQ-015 In FREE, when start=1 and annul=0 with opdata2!=0, SHALL go to ON, latch the operands and clear the counter to 0.
REQ-016 In FREE, for any other input combination, SHALL stay in FREE.
REQ-017 When latching with signed_div=1, SHALL store the absolute value of each negative operand and record both operand signs.
REQ-018 Changes to opdata1, opdata2 or signed_div after the latch edge SHALL have no effect.
REQ-019 In BYZERO, SHALL go to END on the next edge with result=0.
REQ-020 In ON, SHALL perform one restoring shift-subtract step per cycle, producing 1 quotient bit MSB-first, and increment the counter.
REQ-021 In ON, when counter=WIDTH, SHALL go to END and register the sign-corrected result.
REQ-022 Signed correction: SHALL negate the quotient when the operand signs differ; the remainder SHALL take the sign of the dividend.
REQ-023 Signed 0x80000000 / 0xFFFFFFFF SHALL yield quotient 0x80000000 and remainder 0 (wrap, no trap).
REQ-024 annul=1 in BYZERO or ON SHALL force FREE on the next edge with ready=0 and result=0, overriding all other transitions.
REQ-025 start falling while in ON or BYZERO SHALL NOT abort; the division runs to END.
REQ-026 In END, ready=1 and result SHALL be held stable.
REQ-027 In END, start=0 SHALL cause transition to FREE with ready=0 and result=0 on the next edge.
REQ-028 In END, start held at 1 SHALL cause it to stay in END; a new division requires start to drop to 0 first.
REQ-029 busy SHALL be 1 exactly when the state is BYZERO or ON, decoded from the state register only.
REQ-030 Latency with a nonzero divisor: ready SHALL rise on the WIDTH+2 edge after the edge that samples start (34 edges for WIDTH=32).
REQ-031 Latency for divide-by-zero: ready SHALL rise on the 2nd edge after the sampling edge.
REQ-032 All arithmetic SHALL be WIDTH+1 bits internally; the partial remainder SHALL never overflow.

Reset
REQ-033 rst=0 SHALL force state=FREE, counter=0, latched operands=0, result=0, ready=0 and busy=0 asynchronously.
REQ-034 Reset asserted mid-division (ON or END) SHALL discard the operation with no partial result visible.
REQ-035 After rst returns to 1, the first edge with start=1 SHALL begin a new division normally.

Verification
REQ-036 Unsigned 0xFFFFFFFF / 0x00000010, start held -> ready on edge 34, result={0x0000000F,0x0FFFFFFF}, busy high for edges 1-33.
REQ-037 Signed 0xFFFFFFF9 (-7) / 0x00000002 -> result={0xFFFFFFFF,0xFFFFFFFD}; also 7 / -2 -> {0x00000001,0xFFFFFFFD}.
REQ-038 Divide by zero, opdata1=0x12345678, opdata2=0 -> ready on edge 2, result=0; start kept high 5 more cycles -> ready and result unchanged.
REQ-039 annul pulsed at edge 10 of an ON division -> next edge state FREE, busy=0, ready never asserted; following start computes 100/7 -> {2,14}.
REQ-040 Signed 0x80000000 / 0xFFFFFFFF -> {0x00000000,0x80000000}, no X on any output.
REQ-041 rst driven low between clock edges during ON -> ready, busy and result go to 0 without a clock edge; a division started after rst=1 matches the reference model.

Source files
------------

// File: rtl/div_seq.sv
`default_nettype none
// ============================================================================
// Module      : div_seq
// Description : Multi-cycle restoring divider (signed/unsigned) with
//               divide-by-zero shortcut, annul and start/consume handshake.
// Revision    : 1.0
// ============================================================================
module div_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 start,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 busy
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        END    = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(WIDTH);

    state_t               state_q,  state_d;
    logic [CNT_W-1:0]     cnt_q,    cnt_d;
    logic [WIDTH-1:0]     rem_q,    rem_d;
    logic [WIDTH-1:0]     quo_q,    quo_d;
    logic [WIDTH-1:0]     dvs_q,    dvs_d;
    logic                 neg_quo_q, neg_quo_d;
    logic                 neg_rem_q, neg_rem_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q,  ready_d;

    logic [WIDTH:0]       w_trial;
    logic [WIDTH:0]       w_diff;
    logic                 w_ge;
    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic [WIDTH-1:0]     w_quo_fix;
    logic [WIDTH-1:0]     w_rem_fix;

    // Partial remainder stays below the divisor, so the WIDTH+1 bit
    // difference has its top bit set exactly when the trial is too small.
    assign w_trial   = {rem_q, quo_q[WIDTH-1]};
    assign w_diff    = w_trial - {1'b0, dvs_q};
    assign w_ge      = ~w_diff[WIDTH];

    assign w_abs1    = (signed_div && opdata1[WIDTH-1]) ? -opdata1 : opdata1;
    assign w_abs2    = (signed_div && opdata2[WIDTH-1]) ? -opdata2 : opdata2;
    assign w_quo_fix = neg_quo_q ? -quo_q : quo_q;
    assign w_rem_fix = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        case (state_q)
            FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start && !annul) begin
                    if (opdata2 == '0) begin
                        state_d = BYZERO;
                    end else begin
                        state_d   = ON;
                        cnt_d     = '0;
                        rem_d     = '0;
                        quo_d     = w_abs1;
                        dvs_d     = w_abs2;
                        neg_quo_d = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        neg_rem_d = signed_div & opdata1[WIDTH-1];
                    end
                end
            end
            BYZERO: begin
                result_d = '0;
                if (annul) begin
                    state_d = FREE;
                    ready_d = 1'b0;
                end else begin
                    state_d = END;
                    ready_d = 1'b1;
                end
            end
            ON: begin
                if (annul) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end else if (cnt_q == c_last_cnt) begin
                    state_d  = END;
                    result_d = {w_rem_fix, w_quo_fix};
                    ready_d  = 1'b1;
                end else begin
                    rem_d = w_ge ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
                    quo_d = {quo_q[WIDTH-2:0], w_ge};
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            END: begin
                if (!start) begin
                    state_d  = FREE;
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                state_d  = FREE;
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= FREE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    assign result = result_q;
    assign ready  = ready_q;
    assign busy   = (state_q == BYZERO) || (state_q == ON);

endmodule
`default_nettype wire

// File: tb/tb_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_div_seq
// Description : Self-checking bench for div_seq: vector table, scoreboard
//               queue and hand-written annul / reset sequences.
// Revision    : 1.0
// ============================================================================
module tb_div_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           signed_div;
    logic [W-1:0]   opdata1;
    logic [W-1:0]   opdata2;
    logic           start;
    logic           annul;
    logic [2*W-1:0] result;
    logic           ready;
    logic           busy;

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [63:0] exp;
        int          hold;
    } vec_t;

    vec_t tbl[10];

    div_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference quotient/remainder using 64-bit arithmetic (no INT_MIN/-1 hazard).
    function automatic logic [63:0] model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int hold, input string tag);
        int n;
        int busy_cnt;
        int lat_exp;
        logic [63:0] want;
        logic [63:0] held;
        @(negedge clk);
        signed_div = sgn;
        opdata1    = a;
        opdata2    = b;
        start      = 1'b1;
        exp_q.push_back(exp);
        lat_exp  = (b == 32'd0) ? 2 : 34;
        n        = 0;
        busy_cnt = 0;
        while (n < 60) begin
            @(posedge clk);
            n++;
            #1;
            if (ready) break;
            if (busy) busy_cnt++;
            opdata1    = $urandom;
            opdata2    = $urandom;
            signed_div = 1'($urandom_range(0, 1));
        end
        check($sformatf("%s latency", tag), 80'(n), 80'(lat_exp));
        check($sformatf("%s busy_cycles", tag), 80'(busy_cnt), 80'(lat_exp - 1));
        want = exp_q.pop_front();
        check($sformatf("%s result", tag), {15'd0, busy, result}, {15'd0, 1'b0, want});
        held = result;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("%s hold%0d", tag, i), {14'd0, ready, busy, result}, {14'd0, 1'b1, 1'b0, held});
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("%s release", tag), {14'd0, ready, busy, result}, 80'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [63:0] e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        int          n;

        tbl[0] = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0010, {32'h0000_000F, 32'h0FFF_FFFF}, 1};
        tbl[1] = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1};
        tbl[2] = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 1};
        tbl[3] = '{1'b0, 32'h1234_5678, 32'h0000_0000, 64'd0, 5};
        tbl[4] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000}, 2};
        tbl[5] = '{1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1};
        tbl[6] = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, {32'h8000_0000, 32'h0000_0000}, 1};
        tbl[7] = '{1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, {32'hFFFF_FFFE, 32'h0000_000E}, 1};
        tbl[8] = '{1'b0, 32'd5, 32'd5, {32'd0, 32'd1}, 1};
        tbl[9] = '{1'b0, 32'd3, 32'd7, {32'd3, 32'd0}, 1};

        rst        = 1'b0;
        start      = 1'b0;
        annul      = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        #12;
        check("reset_state", {14'd0, ready, busy, result}, 80'd0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++)
            do_div(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].exp, tbl[i].hold, $sformatf("vec%0d", i));

        for (int i = 0; i < 6; i++) begin
            rs = 1'($urandom_range(0, 1));
            ra = $urandom;
            rb = (i % 2 == 1) ? 32'($urandom_range(1, 255)) : $urandom;
            if (rb == 32'd0) rb = 32'd3;
            do_div(rs, ra, rb, model(rs, ra, rb), 1, $sformatf("rnd%0d", i));
        end

        // Annul during ON: edge 1 samples start, annul is seen on edge 10.
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd3;
        start      = 1'b1;
        @(posedge clk);
        repeat (8) @(posedge clk);
        @(negedge clk);
        annul = 1'b1;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("annul_free", {14'd0, ready, busy, result}, 80'd0);
        @(negedge clk);
        annul = 1'b0;
        n = 0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (ready || busy) n++;
        end
        check("annul_no_ready", 80'(n), 80'd0);
        do_div(1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 1, "after_annul");

        // Asynchronous reset between edges while ON.
        @(negedge clk);
        signed_div = 1'b1;
        opdata1    = 32'hDEAD_BEEF;
        opdata2    = 32'h0000_1234;
        start      = 1'b1;
        repeat (12) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_on", {14'd0, ready, busy, result}, 80'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Asynchronous reset between edges while in END with a visible result.
        @(negedge clk);
        signed_div = 1'b0;
        opdata1    = 32'd1000;
        opdata2    = 32'd7;
        start      = 1'b1;
        n = 0;
        while (n < 60 && !ready) begin
            @(posedge clk);
            n++;
            #1;
        end
        check("end_before_rst", {15'd0, ready, result}, {15'd0, 1'b1, 32'd6, 32'd142});
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_end", {14'd0, ready, busy, result}, 80'd0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        rs = 1'b1;
        ra = $urandom;
        rb = 32'($urandom_range(1, 100000));
        do_div(rs, ra, rb, model(rs, ra, rb), 1, "after_rst");

        check("scoreboard_empty", 80'(exp_q.size()), 80'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
